// File: rtl/bus_sram_responder.sv
// rtl/bus_sram_responder.sv - word-addressed SRAM responder for the req/gnt/rvalid bus
// Fixed-latency in-order responses, byte-enabled writes, optional periodic grant throttling.
module bus_sram_responder #(
    parameter int unsigned MemDepth    = 1024,
    parameter logic [31:0] BaseAddr    = 32'h0010_0000,
    parameter int unsigned RespLatency = 1,
    parameter int unsigned StallEvery  = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dev_req_i,
    input  logic        dev_we_i,
    input  logic [31:0] dev_addr_i,
    input  logic [3:0]  dev_be_i,
    input  logic [31:0] dev_wdata_i,
    output logic        dev_gnt_o,
    output logic        dev_rvalid_o,
    output logic [31:0] dev_rdata_o,
    output logic        dev_err_o
);

    localparam int unsigned IdxW = (MemDepth > 1) ? $clog2(MemDepth) : 1;
    localparam logic [31:0] Span = 32'(4 * MemDepth);

    if (RespLatency < 1 || RespLatency > 4) begin : g_bad_latency
        $fatal(1, "bus_sram_responder: RespLatency must be in 1..4");
    end
    if ((MemDepth & (MemDepth - 1)) != 0) begin : g_bad_depth
        $fatal(1, "bus_sram_responder: MemDepth must be a power of two");
    end

    logic                 r_stall;
    logic [31:0]          r_grant_cnt;
    logic                 w_gnt;
    logic [31:0]          w_offset;
    logic                 w_in_range;
    logic                 w_aligned;
    logic                 w_err;
    logic [IdxW-1:0]      w_idx;
    logic [31:0]          w_stage0_rdata;
    logic [31:0]          r_mem [MemDepth];
    logic [RespLatency-1:0] r_pipe_valid;
    logic [RespLatency-1:0] r_pipe_err;
    logic [31:0]          r_pipe_rdata [RespLatency];

    assign w_gnt      = dev_req_i & ~r_stall;
    assign dev_gnt_o  = w_gnt;

    // Subtraction wraps addresses below the base to large values so one compare covers both ends.
    assign w_offset   = dev_addr_i - BaseAddr;
    assign w_in_range = (w_offset < Span);
    assign w_aligned  = (dev_addr_i[1:0] == 2'b00);
    assign w_err      = ~w_in_range | ~w_aligned;
    assign w_idx      = w_offset[2 +: IdxW];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_grant_cnt <= '0;
            r_stall     <= 1'b0;
        end else begin
            r_stall <= 1'b0;
            if (StallEvery != 0 && w_gnt) begin
                if (r_grant_cnt == 32'(StallEvery - 1)) begin
                    r_grant_cnt <= '0;
                    r_stall     <= 1'b1;
                end else begin
                    r_grant_cnt <= r_grant_cnt + 32'd1;
                end
            end
        end
    end

    // Storage is deliberately not reset so contents survive a mid-run reset.
    always_ff @(posedge clk_i) begin
        if (w_gnt && dev_we_i && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (dev_be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= dev_wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_stage0_rdata = '0;
        if (w_gnt && !dev_we_i && !w_err) begin
            w_stage0_rdata = r_mem[w_idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pipe_valid <= '0;
            r_pipe_err   <= '0;
            for (int i = 0; i < RespLatency; i++) begin
                r_pipe_rdata[i] <= '0;
            end
        end else begin
            r_pipe_valid[0] <= w_gnt;
            r_pipe_err[0]   <= w_gnt & w_err;
            r_pipe_rdata[0] <= w_stage0_rdata;
            for (int i = 1; i < RespLatency; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_err[i]   <= r_pipe_err[i-1];
                r_pipe_rdata[i] <= r_pipe_rdata[i-1];
            end
        end
    end

    assign dev_rvalid_o = r_pipe_valid[RespLatency-1];
    assign dev_err_o    = r_pipe_valid[RespLatency-1] & r_pipe_err[RespLatency-1];
    assign dev_rdata_o  = r_pipe_valid[RespLatency-1] ? r_pipe_rdata[RespLatency-1] : 32'h0;

endmodule

// File: tb/tb_bus_sram_responder.sv
// tb/tb_bus_sram_responder.sv - scoreboard bench for bus_sram_responder
module tb_bus_sram_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0010_0000;
    localparam int unsigned LAT   = 4;
    localparam int unsigned STALL = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        dev_req_i = 1'b0;
    logic        dev_we_i = 1'b0;
    logic [31:0] dev_addr_i = '0;
    logic [3:0]  dev_be_i = '0;
    logic [31:0] dev_wdata_i = '0;
    logic        dev_gnt_o;
    logic        dev_rvalid_o;
    logic [31:0] dev_rdata_o;
    logic        dev_err_o;

    bus_sram_responder #(
        .MemDepth(DEPTH), .BaseAddr(BASE), .RespLatency(LAT), .StallEvery(STALL)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .dev_req_i(dev_req_i), .dev_we_i(dev_we_i), .dev_addr_i(dev_addr_i),
        .dev_be_i(dev_be_i), .dev_wdata_i(dev_wdata_i),
        .dev_gnt_o(dev_gnt_o), .dev_rvalid_o(dev_rvalid_o),
        .dev_rdata_o(dev_rdata_o), .dev_err_o(dev_err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [int];
    int          total = 0;
    int          bad = 0;
    bit          prev_g = 1'b0;
    int          n_grants = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input bit we, input logic [31:0] addr,
                                   input logic [3:0] be, input logic [31:0] wdata);
        exp_t        e;
        logic [31:0] off;
        logic [31:0] w;
        int          idx;
        off     = addr - BASE;
        e.err   = (off >= 32'(4 * DEPTH)) || (addr % 4 != 0);
        e.rdata = 32'h0;
        e.due   = 0;
        if (!e.err) begin
            idx = int'(off / 4);
            if (we) begin
                w = ref_mem.exists(idx) ? ref_mem[idx] : 32'hx;
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
                end
                ref_mem[idx] = w;
            end else begin
                e.rdata = ref_mem.exists(idx) ? ref_mem[idx] : 32'hx;
            end
        end
        return e;
    endfunction

    // Expected grant: low only in the cycle right after every STALL-th grant.
    task automatic issue(input bit we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
        exp_t e;
        bit   exp_g;
        int   tries = 0;
        dev_req_i   = 1'b1;
        dev_we_i    = we;
        dev_addr_i  = addr;
        dev_be_i    = be;
        dev_wdata_i = wdata;
        forever begin
            #1;
            exp_g = !(prev_g && (n_grants % STALL == 0));
            check("gnt", 32'(dev_gnt_o), 32'(exp_g));
            if (dev_gnt_o) begin
                e = model(we, addr, be, wdata);
                e.due = cyc + LAT;
                exp_q.push_back(e);
                n_grants++;
                @(negedge clk_i);
                prev_g = 1'b1;
                break;
            end
            tries++;
            if (tries > 4) begin
                total++;
                bad++;
                $display("FAIL gnt_timeout: got no grant for addr %h after %0d cycles expected grant", addr, tries);
                @(negedge clk_i);
                prev_g = 1'b0;
                break;
            end
            @(negedge clk_i);
            prev_g = 1'b0;
        end
        dev_req_i = 1'b0;
    endtask

    task automatic idle(input int n);
        dev_req_i = 1'b0;
        repeat (n) begin
            #1;
            check("gnt_idle", 32'(dev_gnt_o), 32'h0);
            @(negedge clk_i);
            prev_g = 1'b0;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (dev_rvalid_o) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_rvalid: got rvalid=1 expected no response at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rvalid_cycle", 32'(cyc), 32'(e.due));
                    check("err", 32'(dev_err_o), 32'(e.err));
                    check("rdata", dev_rdata_o, e.rdata);
                end
            end else begin
                check("idle_rdata", dev_rdata_o, 32'h0);
                check("idle_err", 32'(dev_err_o), 32'h0);
                if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL missing_rvalid: got rvalid=0 expected response due at cycle %0d (now %0d)",
                             exp_q[0].due, cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] addr;
        int          sel;
        repeat (2) @(negedge clk_i);
        #1;
        check("reset_rvalid", 32'(dev_rvalid_o), 32'h0);
        check("reset_rdata", dev_rdata_o, 32'h0);
        check("reset_err", 32'(dev_err_o), 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 16; i++) issue(1'b1, BASE + 32'(4 * i), 4'hf, $urandom);

        issue(1'b1, BASE, 4'hf, 32'hCAFE_F00D);
        issue(1'b0, BASE, 4'hf, 32'h0);
        issue(1'b1, BASE + 32'h10, 4'hf, 32'h1122_3344);
        issue(1'b1, BASE + 32'h10, 4'b0101, 32'hAABB_CCDD);
        issue(1'b0, BASE + 32'h10, 4'h0, 32'h0);
        issue(1'b1, BASE + 32'h10, 4'h0, 32'hFFFF_FFFF);
        issue(1'b0, BASE + 32'h10, 4'h3, 32'h0);
        idle(2);
        issue(1'b1, BASE + 32'(4 * DEPTH - 4), 4'hf, 32'h5A5A_A5A5);
        issue(1'b0, BASE + 32'(4 * DEPTH - 4), 4'hf, 32'h0);
        issue(1'b1, 32'h0010_1000, 4'hf, 32'h0BAD_0001);
        issue(1'b0, 32'h000F_FFFC, 4'hf, 32'h0);
        issue(1'b1, 32'h0010_0002, 4'hf, 32'h0BAD_0002);
        issue(1'b0, 32'h0010_0000, 4'hf, 32'h0);
        idle(1);
        issue(1'b1, BASE + 32'h20, 4'hf, 32'hDEAD_BEEF);
        issue(1'b0, BASE + 32'h20, 4'hf, 32'h0);
        issue(1'b0, BASE + 32'h24, 4'hf, 32'h0);
        idle(LAT + 2);

        repeat (300) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       addr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
                1:       addr = BASE - 32'(4 * $urandom_range(1, 4));
                2:       addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
                default: addr = BASE + 32'(4 * $urandom_range(0, 15));
            endcase
            issue(1'($urandom_range(0, 1)), addr, 4'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(LAT + 3);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        issue(1'b0, BASE + 32'h10, 4'hf, 32'h0);
        idle(1);
        rst_ni = 1'b0;
        #1;
        check("midreset_rvalid", 32'(dev_rvalid_o), 32'h0);
        check("midreset_rdata", dev_rdata_o, 32'h0);
        check("midreset_err", 32'(dev_err_o), 32'h0);
        exp_q.delete();
        prev_g   = 1'b0;
        n_grants = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle(LAT + 2);
        issue(1'b0, BASE + 32'h10, 4'hf, 32'h0);
        issue(1'b0, BASE + 32'(4 * DEPTH - 4), 4'hf, 32'h0);
        idle(LAT + 2);
        check("final_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_sram_responder.md
Name: bus_sram_responder

Overview:
- Simulation-only bus device (responder) for the req/gnt/rvalid protocol driven by the compliance testutil host port and the core data port.
- Backs a word-addressed SRAM; serves reads and byte-enabled writes with fixed, parameterised response latency and optional grant throttling.
- Sits on the compliance bench bus as the signature/data memory that the testutil host reads back.

Parameters:
- MemDepth, 1024, number of 32-bit words; must be a power of two.
- BaseAddr, 32'h0010_0000, byte address of word 0; aligned to 4*MemDepth.
- RespLatency, 1, cycles from grant to rvalid; legal range 1..4.
- StallEvery, 0, grant throttling. 0 means gnt is never withheld. N>0 means gnt is withheld for exactly one cycle after every N grants.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- dev_req_i  input  1  request valid
- dev_we_i  input  1  1 = write, 0 = read
- dev_addr_i  input  32  byte address
- dev_be_i  input  4  byte enables (writes only)
- dev_wdata_i  input  32  write data
- dev_gnt_o  output  1  request accepted this cycle (combinational)
- dev_rvalid_o  output  1  response valid
- dev_rdata_o  output  32  read data; 0 for writes and errors
- dev_err_o  output  1  error flag, qualified by dev_rvalid_o

Behaviour:
- Reset is asynchronous and active-low, on rst_ni. Reset values:
  - dev_rvalid_o=0, dev_err_o=0, dev_rdata_o=0.
  - Latency pipeline cleared; grant counter=0; stall flag=0.
  - SRAM contents are not reset; they read as X until written.
- Grant:
  - dev_gnt_o = dev_req_i & ~stall_q.
  - A transaction is accepted in each cycle where req&gnt is high; at most one per cycle.
- Throttling (StallEvery=N>0):
  - grant_cnt increments on each grant.
  - When grant_cnt reaches N it wraps to 0 and stall_q is set for the next cycle only.
  - stall_q clears unconditionally after one cycle.
  - While stalled, the host must hold req/addr/we/be/wdata stable (protocol rule). This block does not check it.
- Address decode on an accepted request:
  - in_range = (dev_addr_i - BaseAddr) < 4*MemDepth, computed as 32-bit unsigned, so addresses below BaseAddr wrap large and fail.
  - aligned = dev_addr_i[1:0]==0.
  - word index = (dev_addr_i - BaseAddr)[2+:log2(MemDepth)].
  - err = ~in_range | ~aligned.
- Write (accepted, we=1, err=0):
  - At the granting clock edge, for each i with dev_be_i[i]=1, byte i of mem[index] <= dev_wdata_i byte i.
  - be=4'h0 is legal: no change, normal response.
- Read (accepted, we=0, err=0):
  - mem[index] is sampled at the granting edge, after any write committed in an earlier cycle.
  - A read in the cycle after a write to the same word returns the new data.
- Error: no memory access; response has rdata=0, err=1.
- Response pipeline:
  - RespLatency-stage shift register carrying {valid, err, rdata}.
  - Stage 0 is loaded at the granting edge.
  - dev_rvalid_o/dev_err_o/dev_rdata_o are driven from the final stage, so rvalid rises exactly RespLatency cycles after the grant cycle.
  - Responses are in order.
  - No backpressure: up to RespLatency transactions may be outstanding; back-to-back grants give back-to-back rvalids.
- dev_rdata_o and dev_err_o are 0 whenever dev_rvalid_o=0.
- Reset mid-operation: all in-flight responses are dropped (no rvalid after reset release for pre-reset grants); memory retains its contents.
- Simulation assertions:
  - RespLatency outside 1..4 → $fatal at elaboration.
  - dev_be_i != 4'hf on a read → no error; be is ignored on reads.

Test Plan:
- Defaults. Write 0xCAFEF00D to 0x0010_0000 (be=f), then read 0x0010_0000 → both granted same cycle as req; read rvalid 1 cycle after grant, rdata=0xCAFEF00D, err=0.
- Byte-enable merge. Write 0x11223344 be=f, then 0xAABBCCDD be=4'b0101 to 0x0010_0010, then read → rdata=0x11BB33DD.
- Range and alignment errors. Requests to 0x0010_1000 (one past end, MemDepth=1024), 0x000F_FFFC and 0x0010_0002 → err=1, rdata=0, memory unchanged.
- Back-to-back with RespLatency=3. Write 0xDEADBEEF to 0x0010_0020, then read it next cycle, then read 0x0010_0024 → rvalid in 3 consecutive cycles starting 3 cycles after the first grant; first read returns 0xDEADBEEF.
- Throttling with StallEvery=2. req held high for 6 cycles → gnt pattern 1,1,0,1,1,0; no transaction lost or duplicated; 4 responses.
- Reset mid-flight with RespLatency=4. Grant a read, assert rst_ni low 2 cycles later for 1 cycle → no rvalid after release; outputs 0 during reset; a previously written word reads back intact.
